// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS controller: Moore FSM sequencing fetch/decode/execute/writeback.
// Define MIPS_MC_CTRL_ORI_EN to add the ori instruction (ORIEXEC/ORIWB states).
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] ALUcontrol,
  output logic       zeroimm,
  output logic       illegal
);
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_ORI = 6'b001101;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB,
    BRANCH, ADDIEXEC, ADDIWB, JUMP
`ifdef MIPS_MC_CTRL_ORI_EN
    , ORIEXEC, ORIWB
`endif
  } state_t;

  state_t state;
  logic   funct_ok, op_ok, pcwrite, branch;

  always_comb begin
    funct_ok = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
               (funct == 6'b100101) || (funct == 6'b101010);
    op_ok    = (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_ADDI) ||
               (op == OP_J) || ((op == OP_R) && funct_ok);
`ifdef MIPS_MC_CTRL_ORI_EN
    if (op == OP_ORI) op_ok = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else begin
      case (state)
        FETCH:    state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= funct_ok ? EXECUTE : FETCH;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEXEC;
            OP_J:         state <= JUMP;
`ifdef MIPS_MC_CTRL_ORI_EN
            OP_ORI:       state <= ORIEXEC;
`endif
            default:      state <= FETCH;
          endcase
        end
        MEMADR:   state <= (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:    state <= MEMWB;
        EXECUTE:  state <= ALUWB;
        ADDIEXEC: state <= ADDIWB;
`ifdef MIPS_MC_CTRL_ORI_EN
        ORIEXEC:  state <= ORIWB;
`endif
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    memwrite = 1'b0; irwrite = 1'b0; regwrite = 1'b0; iord = 1'b0;
    memtoreg = 1'b0; regdst = 1'b0; alusrca = 1'b0; alusrcb = 2'b00;
    pcsrc = 2'b00; ALUcontrol = 3'b010; zeroimm = 1'b0; illegal = 1'b0;
    pcwrite = 1'b0; branch = 1'b0;
    case (state)
      FETCH:    begin irwrite = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; end
      DECODE:   begin alusrcb = 2'b11; illegal = ~op_ok; end
      MEMADR:   begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:    iord = 1'b1;
      MEMWB:    begin regwrite = 1'b1; memtoreg = 1'b1; end
      MEMWR:    begin iord = 1'b1; memwrite = 1'b1; end
      EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: ALUcontrol = 3'b110;
          6'b100100: ALUcontrol = 3'b001;
          6'b100101: ALUcontrol = 3'b000;
          6'b101010: ALUcontrol = 3'b111;
          default:   ALUcontrol = 3'b010;
        endcase
      end
      ALUWB:    begin regwrite = 1'b1; regdst = 1'b1; end
      BRANCH:   begin alusrca = 1'b1; ALUcontrol = 3'b110; branch = 1'b1; pcsrc = 2'b01; end
      ADDIEXEC: begin alusrca = 1'b1; alusrcb = 2'b10; end
      ADDIWB:   regwrite = 1'b1;
      JUMP:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
`ifdef MIPS_MC_CTRL_ORI_EN
      ORIEXEC:  begin alusrca = 1'b1; alusrcb = 2'b10; zeroimm = 1'b1; ALUcontrol = 3'b000; end
      ORIWB:    regwrite = 1'b1;
`endif
      default:  ;
    endcase
    pcen = pcwrite | (branch & zero);
    // Reset kills every write strobe at once, not just at the next edge.
    if (reset) begin
      memwrite = 1'b0; irwrite = 1'b0; regwrite = 1'b0; pcen = 1'b0; illegal = 1'b0;
    end
  end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle output signatures for each instruction class.
module tb_mips_mc_ctrl;
  logic       clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] op = 6'b0, funct = 6'b0;
  logic       memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca, zeroimm, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] ALUcontrol;
  int total = 0, bad = 0;

  mips_mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .pcen(pcen),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .ALUcontrol(ALUcontrol), .zeroimm(zeroimm),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {memwrite,irwrite,regwrite,pcen,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,ALUcontrol,zeroimm,illegal}
  logic [16:0] obs;
  assign obs = {memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, ALUcontrol, zeroimm, illegal};

  localparam logic [16:0] V_FETCH  = 17'b0_1_0_1_0_0_0_0_01_00_010_0_0;
  localparam logic [16:0] V_DEC    = 17'b0_0_0_0_0_0_0_0_11_00_010_0_0;
  localparam logic [16:0] V_DECILL = 17'b0_0_0_0_0_0_0_0_11_00_010_0_1;
  localparam logic [16:0] V_MEMADR = 17'b0_0_0_0_0_0_0_1_10_00_010_0_0;
  localparam logic [16:0] V_MEMRD  = 17'b0_0_0_0_1_0_0_0_00_00_010_0_0;
  localparam logic [16:0] V_MEMWB  = 17'b0_0_1_0_0_1_0_0_00_00_010_0_0;
  localparam logic [16:0] V_MEMWR  = 17'b1_0_0_0_1_0_0_0_00_00_010_0_0;
  localparam logic [16:0] V_SUB    = 17'b0_0_0_0_0_0_0_1_00_00_110_0_0;
  localparam logic [16:0] V_ALUWB  = 17'b0_0_1_0_0_0_1_0_00_00_010_0_0;
  localparam logic [16:0] V_BRZ1   = 17'b0_0_0_1_0_0_0_1_00_01_110_0_0;
  localparam logic [16:0] V_BRZ0   = 17'b0_0_0_0_0_0_0_1_00_01_110_0_0;
  localparam logic [16:0] V_IMMWB  = 17'b0_0_1_0_0_0_0_0_00_00_010_0_0;
  localparam logic [16:0] V_JUMP   = 17'b0_0_0_1_0_0_0_0_00_10_010_0_0;
  localparam logic [16:0] V_ORIEX  = 17'b0_0_0_0_0_0_0_1_10_00_000_1_0;

  task automatic test_reset();
    #2;
    total++;
    if ({memwrite, irwrite, regwrite, pcen, illegal} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=00000", {memwrite, irwrite, regwrite, pcen, illegal});
    end
    @(posedge clk); #1;
    total++;
    if ({memwrite, irwrite, regwrite, pcen, illegal} !== 5'b0) begin
      bad++; $display("FAIL reset_held got=%b exp=00000", {memwrite, irwrite, regwrite, pcen, illegal});
    end
    reset = 1'b0;
    @(negedge clk); total++;
    if (obs !== V_FETCH) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs, V_FETCH); end
    @(posedge clk); #1;
    // first edge after release must have performed the fetch
    @(negedge clk); total++;
    if (obs !== V_DECILL) begin bad++; $display("FAIL reset_first_edge got=%b exp=%b", obs, V_DECILL); end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    logic [16:0] e [5] = '{V_FETCH, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB};
    op = 6'b100011; funct = 6'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); total++;
      if (obs !== e[i]) begin bad++; $display("FAIL lw cyc%0d got=%b exp=%b", i + 1, obs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [16:0] e [4] = '{V_FETCH, V_DEC, V_MEMADR, V_MEMWR};
    op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); total++;
      if (obs !== e[i]) begin bad++; $display("FAIL sw cyc%0d got=%b exp=%b", i + 1, obs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype_sub();
    logic [16:0] e [4] = '{V_FETCH, V_DEC, V_SUB, V_ALUWB};
    op = 6'b000000; funct = 6'b100010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); total++;
      if (obs !== e[i]) begin bad++; $display("FAIL sub cyc%0d got=%b exp=%b", i + 1, obs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_decode();
    logic [5:0] f [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] a [5] = '{3'b010, 3'b110, 3'b001, 3'b000, 3'b111};
    op = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      funct = f[i];
      @(posedge clk); #1;  // DECODE
      @(posedge clk); #1;  // EXECUTE
      @(negedge clk); total++;
      if (ALUcontrol !== a[i]) begin
        bad++; $display("FAIL alu_funct%b got=%b exp=%b", f[i], ALUcontrol, a[i]);
      end
      @(posedge clk); #1;  // ALUWB
      @(posedge clk); #1;  // FETCH
    end
  endtask

  task automatic test_beq();
    logic [16:0] e [3] = '{V_FETCH, V_DEC, V_BRZ1};
    op = 6'b000100; zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); total++;
      if (obs !== e[i]) begin bad++; $display("FAIL beq_z1 cyc%0d got=%b exp=%b", i + 1, obs, e[i]); end
      @(posedge clk); #1;
    end
    zero = 1'b0;
    e[2] = V_BRZ0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); total++;
      if (obs !== e[i]) begin bad++; $display("FAIL beq_z0 cyc%0d got=%b exp=%b", i + 1, obs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e [7] = '{V_FETCH, V_DEC, V_MEMADR, V_IMMWB, V_FETCH, V_DEC, V_JUMP};
    op = 6'b001000;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) op = 6'b000010;
      @(negedge clk); total++;
      if (obs !== e[i]) begin bad++; $display("FAIL addi_j cyc%0d got=%b exp=%b", i + 1, obs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [16:0] e [6] = '{V_FETCH, V_DECILL, V_FETCH, V_DECILL, V_FETCH, V_DEC};
    op = 6'b111111; funct = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) op = 6'b000000;
      if (i == 4) op = 6'b000010;
      @(negedge clk); total++;
      if (obs !== e[i]) begin bad++; $display("FAIL illegal cyc%0d got=%b exp=%b", i + 1, obs, e[i]); end
      @(posedge clk); #1;
    end
    @(negedge clk); total++;
    if (obs !== V_JUMP) begin bad++; $display("FAIL illegal_recover got=%b exp=%b", obs, V_JUMP); end
    @(posedge clk); #1;
  endtask

  task automatic test_ori();
`ifdef MIPS_MC_CTRL_ORI_EN
    logic [16:0] e [4] = '{V_FETCH, V_DEC, V_ORIEX, V_IMMWB};
`else
    logic [16:0] e [4] = '{V_FETCH, V_DECILL, V_FETCH, V_DEC};
`endif
    op = 6'b001101;
    for (int i = 0; i < 4; i++) begin
`ifndef MIPS_MC_CTRL_ORI_EN
      if (i == 2) op = 6'b000010;
`endif
      @(negedge clk); total++;
      if (obs !== e[i]) begin bad++; $display("FAIL ori cyc%0d got=%b exp=%b", i + 1, obs, e[i]); end
      @(posedge clk); #1;
    end
`ifndef MIPS_MC_CTRL_ORI_EN
    @(posedge clk); #1;  // finish the jump
`endif
  endtask

  task automatic test_reset_midwrite();
    op = 6'b101011;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); total++;
    if (obs !== V_MEMWR) begin bad++; $display("FAIL midwr_pre got=%b exp=%b", obs, V_MEMWR); end
    #1 reset = 1'b1;
    #1 total++;
    if (memwrite !== 1'b0) begin bad++; $display("FAIL midwr_async got=%b exp=0", memwrite); end
    @(posedge clk); #1;
    total++;
    if ({memwrite, irwrite, regwrite, pcen, illegal} !== 5'b0) begin
      bad++; $display("FAIL midwr_held got=%b exp=00000", {memwrite, irwrite, regwrite, pcen, illegal});
    end
    reset = 1'b0;
    @(negedge clk); total++;
    if (obs !== V_FETCH) begin bad++; $display("FAIL midwr_fetch got=%b exp=%b", obs, V_FETCH); end
    @(posedge clk); #1;
    @(negedge clk); total++;
    if (obs !== V_DEC) begin bad++; $display("FAIL midwr_decode got=%b exp=%b", obs, V_DEC); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    // the reset task leaves the FSM one cycle past an illegal DECODE, back in FETCH
    test_lw();
    test_sw();
    test_rtype_sub();
    test_alu_decode();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_ori();
    test_reset_midwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
